// File: rtl/key_entry_if.sv
// Scancode-in / number-operator-out bundle between the PS/2 receiver, key_entry and the ALU stage.
interface key_entry_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] number;
  logic [3:0] operand;
  logic       op_ctrl;
  logic       ovf;

  modport master (
    output scan_code, scan_valid,
    input  number, operand, op_ctrl, ovf
  );

  modport slave (
    input  scan_code, scan_valid,
    output number, operand, op_ctrl, ovf
  );
endinterface

// File: rtl/key_entry.sv
// Decodes PS/2 set-2 scancodes into a saturating 3-digit decimal entry plus an operator code.
// Latency: outputs update on the edge that samples scan_valid; op_ctrl pulses the following cycle.
// No backpressure: every scan_valid strobe is consumed in the cycle it arrives.
module key_entry (
  input  logic         clk,
  input  logic         rst,
  key_entry_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXT   = 2'd1,
    BREAK = 2'd2
  } state_t;

  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BREAK = 8'hF0;
  localparam logic [7:0] C_ENTER = 8'h5A;
  localparam logic [7:0] C_BKSP  = 8'h66;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic       r_fresh, w_fresh_nxt;
  logic [3:0] r_operand, w_operand_nxt;
  logic       r_ovf, w_ovf_nxt;
  logic       r_op_ctrl;
  logic       w_pulse;

  logic       w_digit_hit;
  logic [3:0] w_digit;
  logic       w_op_hit;
  logic [3:0] w_op_code;
  logic [9:0] w_mac;

  always_comb begin
    w_digit_hit = 1'b1;
    w_digit     = 4'd0;
    case (bus.scan_code)
      8'h45:   w_digit = 4'd0;
      8'h16:   w_digit = 4'd1;
      8'h1E:   w_digit = 4'd2;
      8'h26:   w_digit = 4'd3;
      8'h25:   w_digit = 4'd4;
      8'h2E:   w_digit = 4'd5;
      8'h36:   w_digit = 4'd6;
      8'h3D:   w_digit = 4'd7;
      8'h3E:   w_digit = 4'd8;
      8'h46:   w_digit = 4'd9;
      default: w_digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_op_hit  = 1'b1;
    w_op_code = 4'h0;
    case (bus.scan_code)
      8'h1C:   w_op_code = 4'hA;
      8'h32:   w_op_code = 4'hB;
      8'h21:   w_op_code = 4'hC;
      8'h23:   w_op_code = 4'hD;
      8'h24:   w_op_code = 4'hE;
      8'h2B:   w_op_code = 4'hF;
      default: w_op_hit = 1'b0;
    endcase
  end

  // cnt<3 bounds acc to two digits here, so 10 bits never wraps (max 999).
  assign w_mac = ({2'b00, r_acc} * 10'd10) + {6'd0, w_digit};

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_fresh_nxt   = r_fresh;
    w_operand_nxt = r_operand;
    w_ovf_nxt     = r_ovf;
    w_pulse       = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        IDLE: begin
          if (bus.scan_code == C_EXT) begin
            w_state_nxt = EXT;
          end else if (bus.scan_code == C_BREAK) begin
            w_state_nxt = BREAK;
          end else if (w_digit_hit) begin
            if (r_fresh) begin
              w_acc_nxt   = {4'd0, w_digit};
              w_cnt_nxt   = 2'd1;
              w_fresh_nxt = 1'b0;
              w_ovf_nxt   = 1'b0;
            end else if (r_cnt < 2'd3) begin
              w_cnt_nxt = r_cnt + 2'd1;
              if (w_mac > 10'd255) begin
                w_acc_nxt = 8'd255;
                w_ovf_nxt = 1'b1;
              end else begin
                w_acc_nxt = w_mac[7:0];
              end
            end
          end else if (w_op_hit) begin
            w_operand_nxt = w_op_code;
            w_pulse       = 1'b1;
            w_fresh_nxt   = 1'b1;
          end else if (bus.scan_code == C_ENTER) begin
            if (r_cnt != 2'd0 && !r_fresh) begin
              w_pulse     = 1'b1;
              w_fresh_nxt = 1'b1;
            end
          end else if (bus.scan_code == C_BKSP) begin
            w_acc_nxt   = 8'd0;
            w_cnt_nxt   = 2'd0;
            w_ovf_nxt   = 1'b0;
            w_fresh_nxt = 1'b0;
          end
        end
        EXT: begin
          w_state_nxt = (bus.scan_code == C_BREAK) ? BREAK : IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= 8'd0;
      r_cnt     <= 2'd0;
      r_fresh   <= 1'b1;
      r_operand <= 4'h0;
      r_ovf     <= 1'b0;
      r_op_ctrl <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fresh   <= w_fresh_nxt;
      r_operand <= w_operand_nxt;
      r_ovf     <= w_ovf_nxt;
      // A commit directly behind another is folded into the first so the strobe never stretches.
      r_op_ctrl <= w_pulse & ~r_op_ctrl;
    end
  end

  assign bus.number  = r_acc;
  assign bus.operand = r_operand;
  assign bus.op_ctrl = r_op_ctrl;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_key_entry.sv
// Directed scancode sequences; expected outputs are queued per strobe and checked by a separate monitor.
module tb_key_entry;

  logic clk;
  logic rst;

  key_entry_if bus ();

  key_entry dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] num;
    logic [3:0] opd;
    logic       ovf;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic sv_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each call occupies one cycle; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] c, input logic [7:0] n, input logic [3:0] o,
                      input logic ov, input logic p);
    exp_t x;
    x.num = n; x.opd = o; x.ovf = ov; x.pulse = p;
    exp_q.push_back(x);
    bus.scan_code  = c;
    bus.scan_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.scan_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic [7:0] junk);
    bus.scan_code = junk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) sv_q <= 1'b0;
    else     sv_q <= bus.scan_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sv_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("number",  {24'd0, bus.number},  {24'd0, e.num});
          chk("operand", {28'd0, bus.operand}, {28'd0, e.opd});
          chk("ovf",     {31'd0, bus.ovf},     {31'd0, e.ovf});
          chk("op_ctrl", {31'd0, bus.op_ctrl}, {31'd0, e.pulse});
        end
      end else begin
        chk("op_ctrl_quiet", {31'd0, bus.op_ctrl}, 32'd0);
      end
    end
  end

  initial begin
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    rst = 1'b1;
    #3;
    chk("rst_number",  {24'd0, bus.number},  32'd0);
    chk("rst_operand", {28'd0, bus.operand}, 32'd0);
    chk("rst_op_ctrl", {31'd0, bus.op_ctrl}, 32'd0);
    chk("rst_ovf",     {31'd0, bus.ovf},     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 8'h00);

    // Enter straight after reset carries no digits
    send(8'h5A, 8'd0, 4'h0, 1'b0, 1'b0);
    idle(1, 8'h00);

    // 1, 0, Enter -> 10 and a commit; a second Enter is ignored
    send(8'h16, 8'd1,  4'h0, 1'b0, 1'b0);
    send(8'h45, 8'd10, 4'h0, 1'b0, 1'b0);
    send(8'h5A, 8'd10, 4'h0, 1'b0, 1'b1);
    idle(1, 8'h00);
    send(8'h5A, 8'd10, 4'h0, 1'b0, 1'b0);
    idle(1, 8'h00);

    // Operator B, then a fresh entry 1,0,0 -> 100
    send(8'h32, 8'd10,  4'hB, 1'b0, 1'b1);
    idle(1, 8'h00);
    send(8'h16, 8'd1,   4'hB, 1'b0, 1'b0);
    send(8'h45, 8'd10,  4'hB, 1'b0, 1'b0);
    send(8'h45, 8'd100, 4'hB, 1'b0, 1'b0);
    send(8'h5A, 8'd100, 4'hB, 1'b0, 1'b1);
    idle(1, 8'h00);

    // 2,8,8 saturates; 4th digit ignored; backspace clears; Enter then ignored
    send(8'h1E, 8'd2,   4'hB, 1'b0, 1'b0);
    send(8'h3E, 8'd28,  4'hB, 1'b0, 1'b0);
    send(8'h3E, 8'd255, 4'hB, 1'b1, 1'b0);
    send(8'h16, 8'd255, 4'hB, 1'b1, 1'b0);
    send(8'h66, 8'd0,   4'hB, 1'b0, 1'b0);
    send(8'h5A, 8'd0,   4'hB, 1'b0, 1'b0);

    // Release / extended sequences are discarded
    send(8'h16, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'hF0, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'h16, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'hE0, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'hF0, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'h5A, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'hE0, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'h75, 8'd1,  4'hB, 1'b0, 1'b0);
    send(8'h2E, 8'd15, 4'hB, 1'b0, 1'b0);
    send(8'h1A, 8'd15, 4'hB, 1'b0, 1'b0);

    // Operators F and A, then saturation cleared by a fresh first digit
    send(8'h2B, 8'd15,  4'hF, 1'b0, 1'b1);
    idle(1, 8'h00);
    send(8'h1C, 8'd15,  4'hA, 1'b0, 1'b1);
    idle(1, 8'h00);
    send(8'h1E, 8'd2,   4'hA, 1'b0, 1'b0);
    send(8'h3E, 8'd28,  4'hA, 1'b0, 1'b0);
    send(8'h46, 8'd255, 4'hA, 1'b1, 1'b0);
    send(8'h24, 8'd255, 4'hE, 1'b1, 1'b1);
    idle(1, 8'h00);
    send(8'h16, 8'd1,   4'hE, 1'b0, 1'b0);

    // Build 85, hold with scan_valid low and a digit code on the bus
    send(8'h66, 8'd0,  4'hE, 1'b0, 1'b0);
    send(8'h3E, 8'd8,  4'hE, 1'b0, 1'b0);
    send(8'h2E, 8'd85, 4'hE, 1'b0, 1'b0);
    idle(4, 8'h16);
    chk("hold_number", {24'd0, bus.number}, 32'd85);
    send(8'hF0, 8'd85, 4'hE, 1'b0, 1'b0);

    // Asynchronous reset between F0 and 16
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_number",  {24'd0, bus.number},  32'd0);
    chk("mid_rst_operand", {28'd0, bus.operand}, 32'd0);
    chk("mid_rst_ovf",     {31'd0, bus.ovf},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h16, 8'd1, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    idle(2, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scan_code  input  8  PS/2 set-2 scancode byte from the PS/2 receiver.
REQ-005 scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-006 number  output  8  registered unsigned decimal accumulator value, fed to the mux/ALU stage.
REQ-007 operand  output  4  registered operator code, fed to the mux/ALU stage.
REQ-008 op_ctrl  output  1  one-cycle commit strobe; downstream latches number or operand on it.
REQ-009 ovf  output  1  registered flag; entered value exceeded 255 and was saturated.

Function
REQ-010 FSM states SHALL be IDLE, EXT and BREAK; only a scan_valid cycle can cause a transition.
REQ-011 IDLE + code 8'hE0 -> EXT; IDLE + 8'hF0 -> BREAK; IDLE + any other code -> decode per REQ-013..018, stay IDLE.
REQ-012 EXT + 8'hF0 -> BREAK; EXT + any other code -> IDLE, code discarded; BREAK + any code -> IDLE, code discarded (key release).
REQ-013 Digit codes SHALL be 45,16,1E,26,25,2E,36,3D,3E,46 (hex) for digits 0..9.
REQ-014 Digit accepted in IDLE: if fresh=1 then acc=d, cnt=1, fresh=0; else if cnt<3 then acc=acc*10+d, cnt=cnt+1; else ignored.
REQ-015 Multiply-add SHALL be computed at 10 bits; a result >255 SHALL load acc=255 and set ovf=1.
REQ-016 Operator keys A,B,C,D,E,F (codes 1C,32,21,23,24,2B) SHALL load operand=4'hA..4'hF and pulse op_ctrl; fresh is set to 1; acc is not changed.
REQ-017 Enter (5A) with cnt>=1 and fresh=0 SHALL pulse op_ctrl and set fresh=1; with no digits since the last commit, Enter is ignored (no pulse).
REQ-018 Backspace (66) SHALL clear acc, cnt and ovf to 0 and set fresh=0; no pulse. All other codes SHALL be ignored.
REQ-019 number SHALL equal acc at all times; number holds its value after a commit until the next digit or backspace.
REQ-020 Latency: for scan_valid in cycle n, number/operand/ovf SHALL update at the edge ending cycle n; op_ctrl SHALL be high in cycle n+1 only.
REQ-021 op_ctrl SHALL never be high for two consecutive cycles; back-to-back scan_valid SHALL each be decoded in order.
REQ-022 ovf SHALL clear when the first digit of a new entry is accepted (fresh=1 path), or on backspace.
REQ-023 scan_valid=0 SHALL leave all state unchanged; scan_code is ignored when scan_valid=0.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, number=0, operand=0, op_ctrl=0, ovf=0, cnt=0, fresh=1, regardless of clk.
REQ-025 Reset asserted mid-sequence (EXT/BREAK pending or a partial number) SHALL discard the pending sequence; the first code after release is decoded in IDLE.

Verification
REQ-026 Codes 16,45 then 5A -> number=1 then 10; op_ctrl one cycle after the 5A strobe; ovf=0.
REQ-027 Code 32 -> operand=4'hB, op_ctrl single pulse; then 16,45,45 -> number=100 (first digit restarts from 1).
REQ-028 Codes 1E,3E,3E (2,8,8) -> number=255, ovf=1; a 4th digit 16 -> no change; 66 -> number=0, ovf=0.
REQ-029 Codes F0,16 -> no change (release discarded); E0,F0,5A -> no op_ctrl; E0,75 -> discarded, state IDLE.
REQ-030 Enter twice after one commit -> only the first produces op_ctrl; Enter right after reset -> no pulse.
REQ-031 rst pulsed between F0 and 16 with number=85 -> all outputs 0 immediately; next 16 -> number=1.
